// File: rtl/multiword_add_seq.sv
// Sequential multi-precision adder: one 16-bit add slice walks the operands
// least-significant chunk first, holding the carry between chunks.
module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  input  logic                  c_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  c_out,
  output logic                  busy
);

  localparam int W    = 16 * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            c_out_q, c_out_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [15:0]     a_chunk_s;
  logic [15:0]     b_chunk_s;
  logic [16:0]     chunk_s;

  // Select the current operand chunks and form the full 17-bit slice sum.
  always_comb begin
    a_chunk_s = 16'h0000;
    b_chunk_s = 16'h0000;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_chunk_s = a_q[16*i +: 16];
        b_chunk_s = b_q[16*i +: 16];
      end else begin
        a_chunk_s = a_chunk_s;
        b_chunk_s = b_chunk_s;
      end
    end
    chunk_s = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {16'h0000, carry_q};
  end

  // Next-state and datapath update for the IDLE/ADD/DONE sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    c_out_d     = c_out_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          idx_d   = {IDXW{1'b0}};
          sum_d   = {W{1'b0}};
          busy_d  = 1'b1;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        carry_d = chunk_s[16];
        for (int i = 0; i < WORDS; i++) begin
          if (idx_q == IDXW'(i)) begin
            sum_d[16*i +: 16] = chunk_s[15:0];
          end else begin
            sum_d[16*i +: 16] = sum_q[16*i +: 16];
          end
        end
        if (idx_q == LAST_IDX) begin
          c_out_d     = chunk_s[16];
          out_valid_d = 1'b1;
          idx_d       = {IDXW{1'b0}};
          state_d     = DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = ADD;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      sum_q       <= {W{1'b0}};
      carry_q     <= 1'b0;
      idx_q       <= {IDXW{1'b0}};
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      c_out_q     <= c_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: directed cases plus random traffic on a
// WORDS=4 and a WORDS=1 instance, checked against an arithmetic model.
module tb_multiword_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, c_in, c_out, busy;
  logic [W-1:0] a, b, sum;

  logic         in_valid1, in_ready1, out_valid1, out_ready1, c_in1, c_out1, busy1;
  logic [15:0]  a1, b1, sum1;

  multiword_add_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .busy(busy)
  );

  multiword_add_seq #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .c_in(c_in1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .c_out(c_out1), .busy(busy1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model for the WORDS=4 instance: one operation in flight,
  // result = a+b+c_in, visible WORDS edges after accept until taken.
  bit           m_pending = 1'b0;
  int           m_age = 0;
  logic [W:0]   m_exp = '0;
  logic         m_valid;
  bit           chk_en = 1'b0;
  assign m_valid = m_pending && (m_age >= WORDS);

  always @(posedge clk) begin
    if (rst) begin
      m_pending = 1'b0;
      m_age     = 0;
    end else if (!m_pending) begin
      if (in_valid) begin
        m_pending = 1'b1;
        m_age     = 0;
        m_exp     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
      end
    end else if (m_age < WORDS) begin
      m_age++;
    end else if (out_ready) begin
      m_pending = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, !m_pending);
      chk("out_valid", out_valid, m_valid);
      chk("busy", busy, m_pending);
      if (m_valid) begin
        chk("sum", sum, m_exp[W-1:0]);
        chk("c_out", c_out, m_exp[W]);
      end
      chk("busy1_vs_in_ready1", busy1, !in_ready1);
    end
  end

  // Handshake counters and the WORDS=1 scoreboard.
  int          hs4 = 0, hs1 = 0, ops4 = 0, ops1 = 0;
  logic [16:0] q1[$];
  logic [16:0] e1;

  always @(posedge clk) begin
    if (rst) begin
      q1.delete();
    end else begin
      if (out_valid && out_ready) hs4++;
      if (in_valid1 && in_ready1) q1.push_back({1'b0, a1} + {1'b0, b1} + {16'h0000, c_in1});
      if (out_valid1 && out_ready1) begin
        hs1++;
        if (q1.size() == 0) begin
          chk("dup1", 1, 0);
        end else begin
          e1 = q1.pop_front();
          chk("sum1", {c_out1, sum1}, e1);
        end
      end
    end
  end

  // Runs one operation with out_ready high; called at a negedge while idle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic [W-1:0] es, input logic ec, input string nm);
    int cyc;
    a = ta; b = tb_; c_in = tc; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    c_in = ~tc;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_latency"}, cyc, WORDS);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_c_out"}, c_out, ec);
    @(negedge clk);
    chk({nm, "_pulse_width"}, out_valid, 0);
    chk({nm, "_in_ready_back"}, in_ready, 1);
  endtask

  task automatic drive4();
    int wc;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; c_in = 1'($urandom);
      in_valid = 1'b1;
      wc = 0;
      while (!in_ready && wc < 200) begin
        @(negedge clk);
        wc++;
      end
      chk("accept_wait4", (wc >= 200), 0);
      @(negedge clk);
      in_valid = 1'b0;
      a = {$urandom, $urandom};
      ops4++;
    end
  endtask

  task automatic drive1();
    int wc;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a1 = 16'($urandom); b1 = 16'($urandom); c_in1 = 1'($urandom);
      in_valid1 = 1'b1;
      wc = 0;
      while (!in_ready1 && wc < 200) begin
        @(negedge clk);
        wc++;
      end
      chk("accept_wait1", (wc >= 200), 0);
      @(negedge clk);
      in_valid1 = 1'b0;
      a1 = 16'($urandom);
      ops1++;
    end
  endtask

  int          drivers_done = 0;
  logic [W-1:0] s0;
  logic        c0;
  int          wc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0; out_ready1 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_c_out", c_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk_en = 1'b1;
    @(negedge clk);
    chk("in_ready_after_release", in_ready, 1);

    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, "ripple1");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, "full_ripple");
    run_op(64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 1'b0,
           64'h0001_0001_0001_0000, 1'b1, "per_chunk");

    // Backpressure: hold result, pulse in_valid while DONE.
    out_ready = 1'b0;
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; c_in = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wc = 0;
    while (!out_valid && wc < 20) begin
      @(negedge clk);
      wc++;
    end
    chk("bp_latency", wc, WORDS);
    chk("bp_sum", sum, 64'h2222_2222_2222_2212);
    s0 = sum; c0 = c_out;
    for (int i = 0; i < 5; i++) begin
      chk("bp_sum_stable", sum, s0);
      chk("bp_c_out_stable", c_out, c0);
      chk("bp_in_ready_low", in_ready, 0);
      in_valid = (i == 2);
      a = {$urandom, $urandom};
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_back", in_ready, 1);
    chk("bp_busy_low", busy, 0);
    for (int i = 0; i < WORDS + 2; i++) begin
      @(negedge clk);
      chk("bp_no_ghost_result", out_valid, 0);
    end

    // Reset after chunk 1 completes.
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c_in = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < WORDS + 1; i++) begin
      @(negedge clk);
      chk("midrst_no_result", out_valid, 0);
    end
    run_op(64'h3, 64'h4, 1'b1, 64'h8, 1'b0, "after_rst");

    // Random traffic on both builds.
    hs4 = 0;
    fork
      begin drive4(); drivers_done++; end
      begin drive1(); drivers_done++; end
      begin
        while (drivers_done < 2) begin
          @(negedge clk);
          out_ready  = ($urandom_range(0, 3) != 0);
          out_ready1 = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1; out_ready1 = 1'b1;
    wc = 0;
    while ((busy || busy1) && wc < 200) begin
      @(negedge clk);
      wc++;
    end
    chk("drain_bound", (wc >= 200), 0);
    chk("no_loss4", hs4, ops4);
    chk("no_loss1", hs1, ops1);
    chk("ops4_count", ops4, 1000);
    chk("q1_empty", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
